// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding
// and the elaboration-time parameter check.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal when the operand is at least 2 bits and the digit size divides it evenly.
    function automatic bit digit_ok(input int unsigned width, input int unsigned digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/sub_digit_slice.sv
// Combinational DIGIT-bit ripple-borrow subtract slice: d = a_d - b_d - bin.
module sub_digit_slice #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] chain;

    always_comb begin
        chain    = '0;
        d        = '0;
        chain[0] = bin;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]       = a_d[i] ^ b_d[i] ^ chain[i];
            chain[i+1] = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & chain[i]);
        end
        bout = chain[DIGIT];
    end

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle diff = a - b, DIGIT bits per clock, LSB digit first, valid/ready on both sides.
// Define SUB_SATURATE_EN to clamp diff on overflow instead of wrapping.
module digit_serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("digit_serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh;
    logic             mode_q, a_msb, b_msb, bchain;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] d_dig;
    logic             bout;
    logic [WIDTH-1:0] raw, res;
    logic             ovf, last;

    sub_digit_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a_d  (a_sh[DIGIT-1:0]),
        .b_d  (b_sh[DIGIT-1:0]),
        .bin  (bchain),
        .d    (d_dig),
        .bout (bout)
    );

    // in_ready must read 0 while reset is held, even though the state is IDLE.
    assign in_ready = (state == IDLE) && rst_n;

    always_comb begin
        raw  = (d_sh >> DIGIT) | (WIDTH'(d_dig) << (WIDTH - DIGIT));
        last = (cnt == CW'(NDIG - 1));
        ovf  = mode_q ? ((a_msb != b_msb) && (raw[WIDTH-1] != a_msb)) : bout;
        res  = raw;
`ifdef SUB_SATURATE_EN
        if (ovf) begin
            if (!mode_q)
                res = '0;
            else if (a_msb)
                res = {1'b1, {(WIDTH-1){1'b0}}};
            else
                res = {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            d_sh      <= '0;
            mode_q    <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            bchain    <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        d_sh   <= '0;
                        mode_q <= mode_signed;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        bchain <= 1'b0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    d_sh   <= raw;
                    bchain <= bout;
                    cnt    <= cnt + 1'b1;
                    // Outputs only change here, so they hold the previous result during CALC.
                    if (last) begin
                        diff      <= res;
                        borrow    <= bout;
                        overflow  <= ovf;
                        zero      <= (res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed, table-driven bench for digit_serial_subtractor (WIDTH=8, DIGIT=2).
module tb_digit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] a, b;
    logic       mode_signed;
    logic       out_valid, out_ready;
    logic [7:0] diff;
    logic       borrow, overflow, zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digit_serial_subtractor #(
        .WIDTH (8),
        .DIGIT (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .mode_signed (mode_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .diff        (diff),
        .borrow      (borrow),
        .overflow    (overflow),
        .zero        (zero)
    );

    typedef struct {
        string      name;
        logic [7:0] va;
        logic [7:0] vb;
        logic       vm;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
        logic       ez;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, return cycles from accept edge to out_valid; leaves result in DONE.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                            output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        a = ta;
        b = tb;
        mode_signed = tm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_ready_calc", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] sat_d4, sat_d5, sat_d6;
        logic       sat_z4;
`ifdef SUB_SATURATE_EN
        sat_d4 = 8'h00; sat_z4 = 1'b1; sat_d5 = 8'h80; sat_d6 = 8'h7F;
`else
        sat_d4 = 8'hFD; sat_z4 = 1'b0; sat_d5 = 8'h7F; sat_d6 = 8'h80;
`endif
        vecs[0] = '{"u_3m1",    8'h03, 8'h01, 1'b0, 8'h02,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{"u_eq",     8'h81, 8'h81, 1'b0, 8'h00,  1'b0, 1'b0, 1'b1};
        vecs[2] = '{"u_4c15",   8'h4C, 8'h15, 1'b0, 8'h37,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{"u_under",  8'h02, 8'h05, 1'b0, sat_d4, 1'b1, 1'b1, sat_z4};
        vecs[4] = '{"s_negov",  8'h80, 8'h01, 1'b1, sat_d5, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{"s_posov",  8'h7F, 8'hFF, 1'b1, sat_d6, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{"s_noov",   8'h05, 8'h07, 1'b1, 8'hFE,  1'b1, 1'b0, 1'b0};
        vecs[7] = '{"u_f8m02",  8'hF8, 8'h02, 1'b0, 8'hF6,  1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff",      {24'd0, diff},      32'd0);
        chk("rst_flags",     {29'd0, borrow, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].va, vecs[i].vb, vecs[i].vm, lat);
            chk({vecs[i].name, "_lat"},  lat, 32'd4);
            chk({vecs[i].name, "_diff"}, {24'd0, diff}, {24'd0, vecs[i].ed});
            chk({vecs[i].name, "_flags"}, {29'd0, borrow, overflow, zero},
                {29'd0, vecs[i].eb, vecs[i].eo, vecs[i].ez});
            finish_op();
        end

        // Backpressure: result held, new operands ignored while DONE.
        start_op(8'h03, 8'h01, 1'b0, lat);
        chk("bp_lat", lat, 32'd4);
        @(negedge clk);
        a = 8'h10; b = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_diff",      {24'd0, diff},      32'd2);
            chk("bp_flags",     {29'd0, borrow, overflow, zero}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_ov", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ir", {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        chk("bp_new_lat",  lat, 32'd4);
        chk("bp_new_diff", {24'd0, diff}, 32'h0F);
        finish_op();

        // Reset after two CALC cycles discards the in-flight result.
        @(negedge clk);
        a = 8'h55; b = 8'h11; mode_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ov",   {31'd0, out_valid}, 32'd0);
        chk("mid_rst_diff", {24'd0, diff},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_ov", {31'd0, out_valid}, 32'd0);
            chk("post_rst_idle",  {31'd0, in_ready},  32'd1);
        end
        start_op(8'hF8, 8'h02, 1'b0, lat);
        chk("post_rst_lat",    lat, 32'd4);
        chk("post_rst_diff",   {24'd0, diff}, 32'hF6);
        chk("post_rst_borrow", {31'd0, borrow}, 32'd0);
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
